// File: rtl/diff_accumulator.sv
// Batch accumulator for the 4-bit subtractor stream: saturating signed sum plus overflow-sample count.
// Latency: result valid one cycle after the N_SAMPLES-th accept; held until taken.
// Backpressure: in_ready only in ACC; DONE holds the result while out_ready is low.
module diff_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       diff,
    input  logic             diff_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ACC_W-1:0] SUM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [ACC_W-1:0] diff_ext;
    logic [ACC_W:0]   wide_sum;
    logic             accept;
    logic             clamp_pos;
    logic             clamp_neg;

    assign diff_ext = {{(ACC_W-4){diff[3]}}, diff};
    assign wide_sum = {sum[ACC_W-1], sum} + {diff_ext[ACC_W-1], diff_ext};
    // Top two bits disagreeing means the sum left the ACC_W-bit signed range.
    assign clamp_pos = (wide_sum[ACC_W:ACC_W-1] == 2'b01);
    assign clamp_neg = (wide_sum[ACC_W:ACC_W-1] == 2'b10);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            sum        <= '0;
            ovf_cnt    <= '0;
            sat        <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACC;
                        sample_cnt <= '0;
                        sum        <= '0;
                        ovf_cnt    <= '0;
                        sat        <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ACC: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (diff_ovf) begin
                            if (ovf_cnt != CNT_MAX)
                                ovf_cnt <= ovf_cnt + 1'b1;
                        end else if (clamp_pos) begin
                            sum <= SUM_MAX;
                            sat <= 1'b1;
                        end else if (clamp_neg) begin
                            sum <= SUM_MIN;
                            sat <= 1'b1;
                        end else begin
                            sum <= wide_sum[ACC_W-1:0];
                        end
                        if (sample_cnt == LAST_CNT) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; it must be reissued from IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/diff_accumulator.md
Name: diff_accumulator

Overview:
- Downstream consumer of the 4-bit two's-complement subtractor stage.
- Accepts a stream of 4-bit signed differences, each with an overflow flag, over a valid/ready handshake.
- Accumulates exactly N_SAMPLES accepted samples into a saturating signed sum and counts the overflowed samples.
- Presents the sum and the count on an output valid/ready handshake, then returns to idle for the next batch.

Parameters:
N_SAMPLES, 4, number of samples accepted per batch (range 1..(2^CNT_W)-1)
ACC_W, 8, width of the signed accumulator (range 5..16)
CNT_W, 3, width of the sample counter and the overflow counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a batch; honoured only in IDLE
in_valid  input  1  diff and diff_ovf are valid
in_ready  output  1  block accepts a sample this cycle
diff  input  4  signed difference from the subtractor stage
diff_ovf  input  1  1 = the subtractor overflowed; diff value is meaningless
out_valid  output  1  sum, ovf_cnt and sat are valid
out_ready  input  1  downstream takes the result
sum  output  ACC_W  signed accumulated sum
ovf_cnt  output  CNT_W  number of samples with diff_ovf=1 in the batch
sat  output  1  sticky: the accumulator clamped at least once in the batch
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready, out_valid, sat and busy are 0. sum, ovf_cnt and the sample counter are 0. Reset mid-batch abandons the batch entirely.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> ACC on the next edge; sum, ovf_cnt, sat and the sample counter clear on that same edge.
- State ACC:
  - in_ready=1, busy=1.
  - An accept occurs on an edge where in_valid=1 and in_ready=1.
  - On an accept with diff_ovf=0: sum <= clamp(sum + sign_extend(diff)) to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. If clamping occurred, sat <= 1. sat never clears within a batch.
  - On an accept with diff_ovf=1: sum is unchanged; ovf_cnt increments, saturating at 2^CNT_W-1.
  - The sample counter increments on every accept.
  - On the accept that brings the counter to N_SAMPLES -> DONE; out_valid=1 on the next cycle, giving a latency of 1 cycle from the last accept.
  - in_valid=0 cycles are stalls: no state change.
  - start is ignored.
- State DONE:
  - in_ready=0, out_valid=1. sum, ovf_cnt and sat are held stable.
  - out_ready=1 -> IDLE on the next edge. out_valid drops; sum, ovf_cnt and sat keep their values until the next start.
  - start is ignored, including when it coincides with out_ready=1; it must be reissued in IDLE.
  - out_ready=0 holds DONE indefinitely.
- Arithmetic:
  - diff is sign-extended from bit 3.
  - Overflow detection is performed on an ACC_W+1-bit intermediate sum.
  - Positive clamping sets sum to 2^(ACC_W-1)-1; negative clamping sets it to -2^(ACC_W-1).
- N_SAMPLES=1: a single accept goes straight to DONE.

Test Plan:
1. Reset mid-batch: start, accept 2 samples (diff=3, then 2), assert rst_n=0 -> immediately state=IDLE, sum=0, ovf_cnt=0, in_ready=0, out_valid=0, with no clock edge needed.
2. Basic batch (defaults): start, then diff = 3, -2 (4'b1110), 7, -8 (4'b1000), all with diff_ovf=0 -> out_valid one cycle after the 4th accept; sum=0, ovf_cnt=0, sat=0.
3. Overflow samples: start, then {diff=5, ovf=0}, {diff=4'b1010, ovf=1}, {diff=2, ovf=0}, {diff=4'b0110, ovf=1} -> sum=7, ovf_cnt=2, sat=0.
4. Saturation (ACC_W=5): start, then diff = 7, 7, 7, -1 -> sum after the 3rd accept is 15 (clamped from 21), final sum=14, sat=1. Negative case: -8, -8, -8, 0 -> sum=-16, sat=1.
5. Handshake stalls: in_valid toggles 1,0,0,1,0,1,1 -> only 4 accepts are counted. out_ready is held 0 for 5 cycles in DONE -> out_valid and sum stay stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
6. Ignored start: start pulsed during ACC and again in DONE coincident with out_ready=1 -> no restart, ends in IDLE. A new start then clears sum and ovf_cnt.
